// File: rtl/hough_accumulator.sv
// Hough vote accumulator: bins (r, angle) votes into a saturating BRAM vote array
// and scans the array on command to report the strongest line.
module hough_accumulator #(
    parameter int N_ANGLES = 45,
    parameter int R_OFFSET = 1024,
    parameter int R_SHIFT  = 3,
    parameter int R_BINS   = 288,
    parameter int COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               vote_valid,
    output logic               vote_ready,
    input  logic [12:0]        vote_r,
    input  logic [7:0]         vote_angle,
    input  logic               scan_start,
    output logic               busy,
    output logic               peak_valid,
    output logic [12:0]        peak_r,
    output logic [7:0]         peak_angle,
    output logic [COUNT_W-1:0] peak_count,
    output logic [15:0]        drop_count
);

    localparam int DEPTH = N_ANGLES * R_BINS;
    localparam int AW    = $clog2(DEPTH);
    localparam int AI_W  = $clog2(N_ANGLES);
    localparam int RB_W  = $clog2(R_BINS);
    localparam int SB_W  = 14 - R_SHIFT;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

    function automatic logic [COUNT_W-1:0] sat_inc_count(input logic [COUNT_W-1:0] v);
        if (&v) return v;
        else    return v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [15:0] sat_inc_drop(input logic [15:0] v);
        if (&v) return v;
        else    return v + 16'd1;
    endfunction

    state_t              state_r, state_s;
    logic                busy_r, vote_ready_r;
    logic [AW-1:0]       clr_addr_r;

    logic signed [13:0]  sum_s;
    logic [SB_W-1:0]     rbin_s;
    logic [5:0]          angle_idx_s;
    logic                in_range_s, accept_s;
    logic [AW-1:0]       addr_s;

    logic                p1_valid_r, p2_valid_r, w1_valid_r, w2_valid_r;
    logic [AW-1:0]       p1_addr_r, p2_addr_r, w1_addr_r, w2_addr_r;
    logic [COUNT_W-1:0]  w1_data_r, w2_data_r, base_s, inc_s;
    logic [15:0]         drop_count_r;

    logic [AI_W-1:0]     scan_aidx_r, cmp_aidx_r, max_aidx_r;
    logic [RB_W-1:0]     scan_rbin_r, cmp_rbin_r, max_rbin_r;
    logic [AW-1:0]       scan_addr_r;
    logic [1:0]          tail_r;
    logic                cmp_valid_r;
    logic [COUNT_W-1:0]  max_count_r;

    logic                peak_valid_r;
    logic [12:0]         peak_r_r;
    logic [7:0]          peak_angle_r;
    logic [COUNT_W-1:0]  peak_count_r;

    logic                ram_we_s;
    logic [AW-1:0]       ram_waddr_s, ram_raddr_s;
    logic [COUNT_W-1:0]  ram_wdata_s, rd_data_r;
    logic [COUNT_W-1:0]  mem_r [DEPTH];

    assign vote_ready = vote_ready_r;
    assign busy       = busy_r;
    assign peak_valid = peak_valid_r;
    assign peak_r     = peak_r_r;
    assign peak_angle = peak_angle_r;
    assign peak_count = peak_count_r;
    assign drop_count = drop_count_r;

    // Next-state selection; clear overrides every state
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = ST_CLEAR;
        end else begin
            case (state_r)
                ST_CLEAR: if (clr_addr_r == LAST_ADDR) state_s = ST_ACCUM; else state_s = ST_CLEAR;
                ST_ACCUM: if (scan_start) state_s = ST_DRAIN; else state_s = ST_ACCUM;
                ST_DRAIN: if (!p1_valid_r && !p2_valid_r) state_s = ST_SCAN; else state_s = ST_DRAIN;
                ST_SCAN:  if (tail_r == 2'd2) state_s = ST_ACCUM; else state_s = ST_SCAN;
                default:  state_s = ST_CLEAR;
            endcase
        end
    end

    // State register with status outputs registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_CLEAR;
            busy_r       <= 1'b1;
            vote_ready_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != ST_ACCUM);
            vote_ready_r <= (state_s == ST_ACCUM);
        end
    end

    // Vote address calculation and range check (S0)
    always_comb begin
        sum_s       = $signed({vote_r[12], vote_r}) + $signed(14'(R_OFFSET));
        rbin_s      = sum_s[13:R_SHIFT];
        angle_idx_s = vote_angle[7:2];
        in_range_s  = !sum_s[13] && (rbin_s < SB_W'(R_BINS)) &&
                      (angle_idx_s < 6'(N_ANGLES)) && (vote_angle[1:0] == 2'b00);
        accept_s    = vote_valid && vote_ready_r && !clear;
        addr_s      = AW'(angle_idx_s) * AW'(R_BINS) + AW'(rbin_s);
    end

    // Clear sweep address
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr_r <= {AW{1'b0}};
        end else if (clear) begin
            clr_addr_r <= {AW{1'b0}};
        end else if (state_r == ST_CLEAR && clr_addr_r != LAST_ADDR) begin
            clr_addr_r <= clr_addr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            clr_addr_r <= {AW{1'b0}};
        end
    end

    // Vote pipeline plus write history used to bypass the one-cycle BRAM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_valid_r <= 1'b0;
            p2_valid_r <= 1'b0;
            w1_valid_r <= 1'b0;
            w2_valid_r <= 1'b0;
            p1_addr_r  <= {AW{1'b0}};
            p2_addr_r  <= {AW{1'b0}};
            w1_addr_r  <= {AW{1'b0}};
            w2_addr_r  <= {AW{1'b0}};
            w1_data_r  <= {COUNT_W{1'b0}};
            w2_data_r  <= {COUNT_W{1'b0}};
        end else if (clear) begin
            p1_valid_r <= 1'b0;
            p2_valid_r <= 1'b0;
            w1_valid_r <= 1'b0;
            w2_valid_r <= 1'b0;
        end else begin
            p1_valid_r <= accept_s && in_range_s;
            p1_addr_r  <= addr_s;
            p2_valid_r <= p1_valid_r;
            p2_addr_r  <= p1_addr_r;
            w1_valid_r <= p2_valid_r;
            w1_addr_r  <= p2_addr_r;
            w1_data_r  <= inc_s;
            w2_valid_r <= w1_valid_r;
            w2_addr_r  <= w1_addr_r;
            w2_data_r  <= w1_data_r;
        end
    end

    // S2 operand: the newest write to the same bin wins over the BRAM read
    always_comb begin
        base_s = rd_data_r;
        if (w1_valid_r && (w1_addr_r == p2_addr_r)) begin
            base_s = w1_data_r;
        end else if (w2_valid_r && (w2_addr_r == p2_addr_r)) begin
            base_s = w2_data_r;
        end else begin
            base_s = rd_data_r;
        end
        inc_s = sat_inc_count(base_s);
    end

    // Rejected-vote counter, zeroed whenever a clear begins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_r <= 16'd0;
        end else if (clear) begin
            drop_count_r <= 16'd0;
        end else if (accept_s && !in_range_s) begin
            drop_count_r <= sat_inc_drop(drop_count_r);
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    // Scan sequencer and running maximum (strict '>' keeps the lowest address on ties)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_aidx_r <= {AI_W{1'b0}};
            scan_rbin_r <= {RB_W{1'b0}};
            scan_addr_r <= {AW{1'b0}};
            tail_r      <= 2'd0;
            cmp_valid_r <= 1'b0;
            cmp_aidx_r  <= {AI_W{1'b0}};
            cmp_rbin_r  <= {RB_W{1'b0}};
            max_aidx_r  <= {AI_W{1'b0}};
            max_rbin_r  <= {RB_W{1'b0}};
            max_count_r <= {COUNT_W{1'b0}};
        end else if (clear) begin
            tail_r      <= 2'd0;
            cmp_valid_r <= 1'b0;
        end else begin
            cmp_valid_r <= (state_r == ST_SCAN) && (tail_r == 2'd0);
            cmp_aidx_r  <= scan_aidx_r;
            cmp_rbin_r  <= scan_rbin_r;
            if (state_r == ST_DRAIN) begin
                scan_aidx_r <= {AI_W{1'b0}};
                scan_rbin_r <= {RB_W{1'b0}};
                scan_addr_r <= {AW{1'b0}};
                tail_r      <= 2'd0;
                max_aidx_r  <= {AI_W{1'b0}};
                max_rbin_r  <= {RB_W{1'b0}};
                max_count_r <= {COUNT_W{1'b0}};
            end else if (state_r == ST_SCAN) begin
                if (tail_r == 2'd0) begin
                    if (scan_addr_r == LAST_ADDR) begin
                        tail_r <= 2'd1;
                    end else if (scan_rbin_r == RB_W'(R_BINS - 1)) begin
                        scan_rbin_r <= {RB_W{1'b0}};
                        scan_aidx_r <= scan_aidx_r + {{(AI_W-1){1'b0}}, 1'b1};
                        scan_addr_r <= scan_addr_r + {{(AW-1){1'b0}}, 1'b1};
                    end else begin
                        scan_rbin_r <= scan_rbin_r + {{(RB_W-1){1'b0}}, 1'b1};
                        scan_addr_r <= scan_addr_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else if (tail_r == 2'd1) begin
                    tail_r <= 2'd2;
                end else begin
                    tail_r <= 2'd0;
                end
                if (cmp_valid_r && (rd_data_r > max_count_r)) begin
                    max_count_r <= rd_data_r;
                    max_aidx_r  <= cmp_aidx_r;
                    max_rbin_r  <= cmp_rbin_r;
                end
            end else begin
                tail_r <= 2'd0;
            end
        end
    end

    // Peak result registers; peak_* hold until the next completed scan
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_valid_r <= 1'b0;
            peak_r_r     <= 13'd0;
            peak_angle_r <= 8'd0;
            peak_count_r <= {COUNT_W{1'b0}};
        end else if (!clear && state_r == ST_SCAN && tail_r == 2'd2) begin
            peak_valid_r <= 1'b1;
            peak_r_r     <= (13'(max_rbin_r) << R_SHIFT) - 13'(R_OFFSET);
            peak_angle_r <= 8'(max_aidx_r) << 2;
            peak_count_r <= max_count_r;
        end else begin
            peak_valid_r <= 1'b0;
        end
    end

    // BRAM port selection: clear sweep, vote write-back, scan or vote read
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = p2_addr_r;
        ram_wdata_s = inc_s;
        ram_raddr_s = p1_addr_r;
        if (state_r == ST_CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_addr_r;
            ram_wdata_s = {COUNT_W{1'b0}};
        end else begin
            ram_we_s    = p2_valid_r;
        end
        if (state_r == ST_SCAN) begin
            ram_raddr_s = scan_addr_r;
        end else begin
            ram_raddr_s = p1_addr_r;
        end
    end

    // Vote array: one write and one synchronous read per cycle, no reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[ram_waddr_s] <= ram_wdata_s;
        end
        rd_data_r <= mem_r[ram_raddr_s];
    end

endmodule

// File: tb/tb_hough_accumulator.sv
// Directed self-checking bench for hough_accumulator: clear/scan, back-to-back
// binning, saturation, rejected votes, tie-break and clear during a scan.
module tb_hough_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        vote_valid;
    logic        vote_ready;
    logic [12:0] vote_r;
    logic [7:0]  vote_angle;
    logic        scan_start;
    logic        busy;
    logic        peak_valid;
    logic [12:0] peak_r;
    logic [7:0]  peak_angle;
    logic [7:0]  peak_count;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hough_accumulator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .vote_valid (vote_valid),
        .vote_ready (vote_ready),
        .vote_r     (vote_r),
        .vote_angle (vote_angle),
        .scan_start (scan_start),
        .busy       (busy),
        .peak_valid (peak_valid),
        .peak_r     (peak_r),
        .peak_angle (peak_angle),
        .peak_count (peak_count),
        .drop_count (drop_count)
    );

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 14000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b required 0 within 14000 cycles", busy);
        end
    endtask

    task automatic send_vote(input int r, input int a);
        int n = 0;
        @(negedge clk);
        while (vote_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (vote_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL vote_ready_timeout: vote_ready=%b required 1", vote_ready);
        end
        vote_valid = 1'b1;
        vote_r     = 13'(r);
        vote_angle = 8'(a);
        @(posedge clk);
    endtask

    task automatic vote_idle();
        @(negedge clk);
        vote_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_scan();
        int n = 0;
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        while (peak_valid !== 1'b1 && n < 14000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (peak_valid !== 1'b1) begin
            bad++;
            $display("FAIL scan_done: peak_valid=%b required 1 within 14000 cycles", peak_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear = 1'b0; vote_valid = 1'b0; vote_r = 13'd0; vote_angle = 8'd0; scan_start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, vote_ready, peak_valid} !== 3'b100) begin
            bad++;
            $display("FAIL reset_flags: busy/ready/pv=%b required 100", {busy, vote_ready, peak_valid});
        end
        total++;
        if ({peak_r, peak_angle, peak_count, drop_count} !== 45'd0) begin
            bad++;
            $display("FAIL reset_values: r=%0d a=%0d c=%0d d=%0d required all 0",
                     peak_r, peak_angle, peak_count, drop_count);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({busy, vote_ready} !== 2'b10) begin
            bad++;
            $display("FAIL clearing_flags: busy/ready=%b required 10", {busy, vote_ready});
        end
    endtask

    // Rejected votes leave the array empty, so the scan reports bin 0 with count 0.
    task automatic test_drop_and_zero();
        wait_idle();
        send_vote(1280, 0);
        send_vote(-1025, 0);
        send_vote(0, 180);
        send_vote(0, 6);
        send_vote(1279, 176);
        vote_idle();
        total++;
        if (drop_count !== 16'd4) begin
            bad++;
            $display("FAIL drop_count: got %0d required 4", drop_count);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_idle();
        total++;
        if (drop_count !== 16'd0) begin
            bad++;
            $display("FAIL drop_cleared: got %0d required 0", drop_count);
        end
        send_vote(1280, 0);
        send_vote(0, 2);
        vote_idle();
        run_scan();
        total++;
        if ($signed(peak_r) !== -13'sd1024 || peak_angle !== 8'd0 || peak_count !== 8'd0) begin
            bad++;
            $display("FAIL zero_scan: r=%0d a=%0d c=%0d required -1024 0 0",
                     $signed(peak_r), peak_angle, peak_count);
        end
        @(negedge clk);
        total++;
        if (peak_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL peak_pulse: pv=%b busy=%b required 0 0", peak_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) send_vote(100, 40);
        send_vote(-300, 92);
        send_vote(-300, 92);
        vote_idle();
        run_scan();
        total++;
        if ($signed(peak_r) !== 13'sd96 || peak_angle !== 8'd40 || peak_count !== 8'd5) begin
            bad++;
            $display("FAIL back_to_back: r=%0d a=%0d c=%0d required 96 40 5",
                     $signed(peak_r), peak_angle, peak_count);
        end
        total++;
        if (drop_count !== 16'd2) begin
            bad++;
            $display("FAIL drop_held: got %0d required 2", drop_count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) send_vote(-1024, 176);
        vote_idle();
        run_scan();
        total++;
        if ($signed(peak_r) !== -13'sd1024 || peak_angle !== 8'd176 || peak_count !== 8'd255) begin
            bad++;
            $display("FAIL saturate: r=%0d a=%0d c=%0d required -1024 176 255",
                     $signed(peak_r), peak_angle, peak_count);
        end
    endtask

    task automatic test_clear_mid_scan();
        int n = 0;
        int pv_seen = 0;
        int ready_seen = 0;
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (peak_valid === 1'b1) pv_seen++;
            if (vote_ready === 1'b1) ready_seen++;
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        while (busy !== 1'b0 && n < 14000) begin
            if (peak_valid === 1'b1) pv_seen++;
            @(negedge clk);
            n++;
        end
        total++;
        if (pv_seen != 0 || ready_seen != 0) begin
            bad++;
            $display("FAIL abort_scan: peak_valid seen %0d vote_ready seen %0d required 0 0",
                     pv_seen, ready_seen);
        end
        total++;
        if (n < 12950 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reclear_len: busy held %0d cycles busy=%b required >=12950 then 0", n, busy);
        end
    endtask

    // Interleaved votes exercise distance-2 hazards; lower address must win the tie.
    task automatic test_tie();
        for (int i = 0; i < 3; i++) begin
            send_vote(0, 8);
            send_vote(0, 4);
        end
        vote_idle();
        run_scan();
        total++;
        if ($signed(peak_r) !== 13'sd0 || peak_angle !== 8'd4 || peak_count !== 8'd3) begin
            bad++;
            $display("FAIL tie: r=%0d a=%0d c=%0d required 0 4 3",
                     $signed(peak_r), peak_angle, peak_count);
        end
    endtask

    initial begin
        test_reset();
        test_drop_and_zero();
        test_back_to_back();
        test_saturate();
        test_clear_mid_scan();
        test_tie();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
